// File: rtl/uart_txrx_pkg.sv
// Shared types and defaults for the 8N1 UART: FSM state encoding, default
// clock/line-rate constants and the divider helper used to size the ticks.
package uart_txrx_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Truncating clock divider; clamped so a counter never ends up zero-length.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned rate_hz);
        int unsigned q;
        q = clk_hz / rate_hz;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-rate tick (TX) and 16x oversample tick (RX) generators.
// Each tick is high for the single cycle in which its counter wraps.
module uart_baud_gen
    import uart_txrx_pkg::*;
#(
    parameter int unsigned TX_DIV = 434,
    parameter int unsigned RX_DIV = 27
) (
    input  logic clk_50m,
    input  logic rst,
    output logic tx_tick,
    output logic rx_tick
);

    localparam int TXW = $clog2(TX_DIV + 1);
    localparam int RXW = $clog2(RX_DIV + 1);

    logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RXW-1:0] rx_cnt_q, rx_cnt_d;

    // Wrap detection and next counts for both dividers.
    always_comb begin
        tx_tick  = (tx_cnt_q == TXW'(TX_DIV - 1));
        rx_tick  = (rx_cnt_q == RXW'(RX_DIV - 1));
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    end

    // Divider counters.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: bit-rate transmitter and 16x oversampling receiver
// sharing one baud generator. TX and RX are fully independent.
//
//   state    | TX meaning                    | RX meaning
//   ST_IDLE  | line high, waiting for wr_en  | waiting for a low line at a tick
//   ST_START | driving start bit (low)       | confirming start at mid-bit
//   ST_DATA  | driving data[idx], LSB first  | sampling 8 bits at mid-bit
//   ST_STOP  | driving stop bit (high)       | checking stop bit, delivering byte
module uart_txrx
    import uart_txrx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);

    localparam int unsigned TX_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned RX_DIV = baud_div(CLK_FREQ, 16 * BAUD);

    logic tx_tick, rx_tick;

    uart_baud_gen #(
        .TX_DIV (TX_DIV),
        .RX_DIV (RX_DIV)
    ) u_baud_gen (
        .clk_50m (clk_50m),
        .rst     (rst),
        .tx_tick (tx_tick),
        .rx_tick (rx_tick)
    );

    uart_state_e tx_state_q, tx_state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        tx_q, tx_d;
    logic        tx_busy_q, tx_busy_d;

    // TX next state; the line level is derived from the next state so it is registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_idx_d   = tx_idx_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            ST_IDLE: if (wr_en) begin
                tx_data_d  = din;
                tx_busy_d  = 1'b1;
                tx_state_d = ST_START;
            end
            ST_START: if (tx_tick) begin
                tx_idx_d   = 3'd0;
                tx_state_d = ST_DATA;
            end
            ST_DATA: if (tx_tick) begin
                if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
                else                  tx_idx_d   = tx_idx_q + 3'd1;
            end
            ST_STOP: if (tx_tick) begin
                tx_busy_d  = 1'b0;
                tx_state_d = ST_IDLE;
            end
            default: tx_state_d = ST_IDLE;
        endcase
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_data_d[tx_idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // TX FSM registers.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            tx_state_q <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_idx_q   <= 3'd0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_idx_q   <= tx_idx_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    uart_state_e rx_state_q, rx_state_d;
    logic        rx_meta_q, rx_sync_q;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        rdy_q, rdy_d;
    logic        rdy_set;

    // RX next state, advanced only on oversample ticks; rdy set beats rdy_clr.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        dout_d     = dout_q;
        rdy_set    = 1'b0;
        if (rx_tick) begin
            case (rx_state_q)
                ST_IDLE: if (!rx_sync_q) begin
                    rx_cnt_d   = 4'd0;
                    rx_state_d = ST_START;
                end
                ST_START: begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = 4'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        // A low stop bit is a framing error: the byte is dropped.
                        if (rx_sync_q) begin
                            dout_d  = rx_shift_q;
                            rdy_set = 1'b1;
                        end
                        rx_state_d = ST_IDLE;
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
        rdy_d = rdy_set | (rdy_q & ~rdy_clr);
    end

    // RX synchroniser and FSM registers; synchroniser resets to the idle level.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            dout_q     <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: fixed and random frames on both directions, checked
// against frames built from the 8N1 rules and a tracked expected dout/rdy.
module tb_uart_txrx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int TX_DIV   = CLK_FREQ / BAUD;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx_w;
    logic       tx, tx_busy, rdy;
    logic [7:0] dout;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_hi_cnt = 0;
    logic [7:0] exp_dout;

    assign rx_w = loop_en ? tx : rx_drv;

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) if (rdy === 1'b1) rdy_hi_cnt++;

    uart_txrx dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx_w),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_wr(input logic [7:0] b);
        @(negedge clk_50m);
        din   = b;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
    endtask

    task automatic clear_rdy(input string tag);
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        check_val({tag, "_rdy_clr"}, rdy, 0);
    endtask

    // Record tx while busy and compare with the ideal 8N1 frame of exp_b.
    task automatic capture_tx(input logic [7:0] exp_b, input string tag);
        logic       samples[$];
        int         start_len;
        int         bad;
        logic [7:0] got;
        check_val({tag, "_busy"}, tx_busy, 1);
        if (tx_busy !== 1'b1) return;
        while (tx_busy === 1'b1 && samples.size() < 12 * TX_DIV) begin
            samples.push_back(tx);
            @(negedge clk_50m);
        end
        start_len = samples.size() - 9 * TX_DIV;
        check_val({tag, "_start_len_ok"}, (start_len >= 1 && start_len <= TX_DIV), 1);
        if (start_len < 1 || start_len > TX_DIV) return;
        bad = 0;
        for (int i = 0; i < samples.size(); i++) begin
            int   k;
            logic e;
            if (i < start_len) begin
                e = 1'b0;
            end else begin
                k = (i - start_len) / TX_DIV;
                e = (k < 8) ? exp_b[k] : 1'b1;
            end
            if (samples[i] !== e) bad++;
        end
        got = 8'h00;
        for (int k = 0; k < 8; k++) got[k] = samples[start_len + k * TX_DIV + TX_DIV / 2];
        check_val({tag, "_bad_bits"}, bad, 0);
        check_val({tag, "_byte"}, got, exp_b);
        check_val({tag, "_idle_high"}, tx, 1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int stop_len);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat ((i == 9) ? stop_len : TX_DIV) @(posedge clk_50m);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        repeat (90000) @(posedge clk_50m);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] tb_b, rb_b;
        int         cnt, hi0;
        logic       found;

        // Reset
        repeat (5) @(posedge clk_50m);
        @(negedge clk_50m);
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", tx_busy, 0);
        check_val("rst_rdy", rdy, 0);
        check_val("rst_dout", dout, 8'h00);
        exp_dout = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk_50m);

        // Transmit 0x41
        pulse_wr(8'h41);
        capture_tx(8'h41, "tx41");

        // Receive 0x35, then overrun with 0xC3
        drive_rx(8'h35, 1'b1, TX_DIV);
        repeat (2) @(negedge clk_50m);
        exp_dout = 8'h35;
        check_val("rx35_rdy", rdy, 1);
        check_val("rx35_dout", dout, exp_dout);
        drive_rx(8'hC3, 1'b1, TX_DIV);
        repeat (2) @(negedge clk_50m);
        exp_dout = 8'hC3;
        check_val("ovr_rdy", rdy, 1);
        check_val("ovr_dout", dout, exp_dout);
        clear_rdy("ovr");

        // Framing error: stop bit low, then line returns idle
        drive_rx(8'h33, 1'b0, (TX_DIV * 3) / 4);
        repeat (2 * TX_DIV) @(negedge clk_50m);
        check_val("frm_rdy", rdy, 0);
        check_val("frm_dout", dout, exp_dout);

        // Quarter-bit glitch
        rx_drv = 1'b0;
        repeat (TX_DIV / 4) @(posedge clk_50m);
        rx_drv = 1'b1;
        repeat (2 * TX_DIV) @(negedge clk_50m);
        check_val("glitch_rdy", rdy, 0);
        check_val("glitch_dout", dout, exp_dout);

        // Loopback 0x46 with an ignored second wr_en
        loop_en = 1'b1;
        pulse_wr(8'h46);
        fork
            capture_tx(8'h46, "loop");
            begin
                repeat (1000) @(negedge clk_50m);
                din   = 8'hFF;
                wr_en = 1'b1;
                @(negedge clk_50m);
                wr_en = 1'b0;
            end
        join
        repeat (TX_DIV) @(negedge clk_50m);
        exp_dout = 8'h46;
        check_val("loop_rdy", rdy, 1);
        check_val("loop_dout", dout, exp_dout);
        clear_rdy("loop");
        cnt = 0;
        for (int i = 0; i < 12 * TX_DIV; i++) begin
            @(negedge clk_50m);
            if (tx_busy === 1'b1) cnt++;
        end
        check_val("loop_no_second_frame", cnt, 0);
        check_val("loop_no_second_rx", rdy, 0);
        loop_en = 1'b0;

        // Reset during data bit 3 of 0xA5
        pulse_wr(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 2 * TX_DIV && !found; i++) begin
            if (tx === 1'b1) found = 1'b1;
            else @(negedge clk_50m);
        end
        check_val("rstmid_bit0_seen", found, 1);
        repeat (3 * TX_DIV + TX_DIV / 2) @(negedge clk_50m);
        check_val("rstmid_bit3_level", tx, 0);
        #2 rst = 1'b0;
        #1;
        check_val("rstmid_tx", tx, 1);
        check_val("rstmid_busy", tx_busy, 0);
        check_val("rstmid_rdy", rdy, 0);
        exp_dout = 8'h00;
        repeat (3) @(negedge clk_50m);
        rst = 1'b1;
        repeat (3) @(negedge clk_50m);
        pulse_wr(8'h30);
        capture_tx(8'h30, "tx30");

        // Random full-duplex traffic; last round holds rdy_clr to test set-over-clear
        for (int r = 0; r < 4; r++) begin
            tb_b = 8'($urandom);
            rb_b = 8'($urandom);
            if (r == 3) rdy_clr = 1'b1;
            hi0 = rdy_hi_cnt;
            fork
                begin
                    pulse_wr(tb_b);
                    capture_tx(tb_b, "rnd_tx");
                end
                drive_rx(rb_b, 1'b1, TX_DIV);
            join
            repeat (2) @(negedge clk_50m);
            exp_dout = rb_b;
            check_val("rnd_dout", dout, exp_dout);
            if (r == 3) begin
                check_val("setwins_pulse", rdy_hi_cnt - hi0, 1);
                check_val("setwins_cleared", rdy, 0);
                rdy_clr = 1'b0;
            end else begin
                check_val("rnd_rdy", rdy, 1);
                clear_rdy("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: one byte-wide transmitter, one byte-wide receiver with 16x oversampling, and a shared baud-rate generator.
- Sits between the chip's top-level pins and the core logic.
- Its receive/echo use is a loopback: when `rdy` is high and `tx_busy` is low, the core reads `dout`, pulses `wr_en` with `din = dout`, and pulses `rdy_clr`.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- TX_DIV, CLK_FREQ/BAUD (truncated, 434), clock cycles per transmitted bit.
- RX_DIV, CLK_FREQ/(16*BAUD) (truncated, 27), clock cycles per receive oversample tick.

Ports:
- clk_50m  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  8  byte to transmit.
- wr_en  in  1  single-cycle transmit request.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high while a frame is in flight.
- rx  in  1  serial input, asynchronous to the clock.
- rdy  out  1  a received byte is valid in `dout`.
- rdy_clr  in  1  single-cycle acknowledge that clears `rdy`.
- dout  out  8  last received byte.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, tx_busy=0, rdy=0, dout=0x00, both baud counters=0, both FSMs in IDLE.
- Baud generator:
  - Free-running TX counter 0..TX_DIV-1 produces a one-cycle tx_tick on wrap.
  - RX counter 0..RX_DIV-1 produces a one-cycle rx_tick on wrap.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - IDLE: if wr_en=1, latch din, set tx_busy=1 on the next edge, go to START.
  - wr_en while tx_busy=1 is ignored; the byte is not queued.
  - START: tx=0 until the next tx_tick, then DATA with bit index 0.
  - DATA: tx=data[index], LSB first. On each tx_tick advance the index; after bit 7's tick go to STOP.
  - STOP: tx=1; on the next tx_tick go to IDLE and clear tx_busy.
  - Frame length is 10 bit periods. The first bit period may be shortened by tick phase, up to one TX_DIV.
- Receiver FSM, states IDLE, START, DATA, STOP, all advanced on rx_tick only:
  - Synchronise rx through a 2-flop synchroniser before use.
  - IDLE: on rx_sync=0 at a tick, go to START with sample count 0.
  - START: at sample count 7 (mid-bit), if rx_sync=1 it was a glitch, so return to IDLE. Otherwise reset the count and go to DATA.
  - DATA: every 16 ticks, sample at mid-bit and shift in LSB first. After 8 bits go to STOP.
  - STOP: after 16 ticks, sample rx_sync.
    - If 1: dout <= shifted byte, rdy <= 1.
    - If 0 (framing error): discard the byte and leave rdy and dout unchanged.
    - Either way, return to IDLE.
- rdy:
  - Set on a valid stop bit; cleared by rdy_clr=1.
  - If set and clear happen in the same cycle, set wins.
  - A new byte arriving while rdy=1 overwrites dout (overrun); rdy stays 1; no error flag.
- Receiver and transmitter run fully independently. Simultaneous TX and RX activity is legal.
- Reset asserted mid-frame aborts both FSMs immediately: tx returns high and no partial byte is delivered.

Decomposition:
- Shared package holds the state encodings (IDLE, START, DATA, STOP) and the default CLK_FREQ/BAUD constants.
- One natural sub-module: uart_baud_gen, producing tx_tick and rx_tick.
- Transmitter and receiver stay as always-blocks in uart_txrx.

Test Plan:
- Reset: hold rst=0 for 5 cycles with rx=1 -> tx=1, tx_busy=0, rdy=0, dout=0x00.
- Transmit 0x41: pulse wr_en with din=0x41 -> tx_busy=1 next cycle; tx emits 0,1,0,0,0,0,0,1,0,1, each bit held TX_DIV cycles; tx_busy=0 after the stop bit.
- Receive 0x35 at BAUD (bits 0,1,0,1,0,1,1,0,0,1) -> rdy=1, dout=0x35; pulse rdy_clr -> rdy=0 next cycle.
- Framing and glitch:
  - Drive the 0x33 frame with the stop bit held 0 -> rdy stays 0, dout unchanged.
  - A 0.25-bit low pulse on rx -> no reception.
- Loopback: connect tx to rx and send 0x46 -> rdy=1, dout=0x46. A wr_en during tx_busy is ignored: a single byte goes on the line.
- Reset mid-frame: assert rst during data bit 3 of a TX of 0xA5 -> tx=1 and tx_busy=0 immediately. After release, a new wr_en of 0x30 transmits correctly.
